// File: rtl/reg_file_pkg.sv
// Shared constants for the parametrised register file: clear-engine state
// encoding and the default geometry used by the datapath top.
package reg_file_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Sequential bulk-clear engine: walks a pointer across every register,
// one entry per cycle, so the file can be flushed without a global reset.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic [ADDR_W-1:0] PTR,
    output logic              CLR_EN
);

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;

    // A CLEAR arriving while already clearing is ignored; the walk never restarts.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CLEAR) begin
                        r_state <= ST_CLEARING;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign PTR    = r_ptr;
    assign CLR_EN = (r_state == ST_CLEARING);

endmodule

// File: rtl/reg_file_param.sv
// Parametrised two-read, one-write register file with optional write bypass,
// optional hardwired-zero register 0 and a sequential bulk-clear engine.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WRITE_DROP
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_writeDrop;
    logic              w_busy;
    logic              w_clrEn;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_wrOpen;
    logic              w_wrAccept;

    reg_file_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLEAR   (CLEAR),
        .BUSY    (w_busy),
        .PTR     (w_ptr),
        .CLR_EN  (w_clrEn)
    );

    // Writes are only open while the clear engine is idle and not being started.
    assign w_wrOpen   = WRITE && !w_busy && !CLEAR;
    assign w_wrAccept = w_wrOpen && !((ZERO_REG != 0) && (INADDRESS == '0));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clrEn) begin
            r_mem[w_ptr] <= '0;
        end else if (w_wrAccept) begin
            r_mem[INADDRESS] <= IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_writeDrop <= 1'b0;
        end else begin
            r_writeDrop <= WRITE && (w_busy || CLEAR);
        end
    end

    // Zero register outranks bypass, which outranks the stored value.
    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] value;
        value = stored;
        if ((BYPASS != 0) && w_wrOpen && (addr == INADDRESS)) begin
            value = IN;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end
        return value;
    endfunction

    always_comb begin
        OUT1 = readPort(OUT1ADDRESS, r_mem[OUT1ADDRESS]);
        OUT2 = readPort(OUT2ADDRESS, r_mem[OUT2ADDRESS]);
    end

    assign BUSY       = w_busy;
    assign WRITE_DROP = r_writeDrop;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: an 8x8 bypassing instance
// and a 16x16 instance with hardwired-zero register 0.
module tb_reg_file_param;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;

    logic [7:0]  aIn;
    logic [2:0]  aInAddr, aO1Addr, aO2Addr;
    logic        aWrite, aClear;
    logic [7:0]  aOut1, aOut2;
    logic        aBusy, aDrop;

    logic [15:0] bIn;
    logic [3:0]  bInAddr, bO1Addr, bO2Addr;
    logic        bWrite, bClear;
    logic [15:0] bOut1, bOut2;
    logic        bBusy, bDrop;

    int assertCount = 0;
    int failCount   = 0;
    int busyCycles;
    int guard;

    reg_file_param #(
        .DATA_W(8), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)
    ) dutA (
        .CLK(CLK), .RESET_N(RESET_N), .IN(aIn), .INADDRESS(aInAddr), .WRITE(aWrite),
        .OUT1ADDRESS(aO1Addr), .OUT2ADDRESS(aO2Addr), .OUT1(aOut1), .OUT2(aOut2),
        .CLEAR(aClear), .BUSY(aBusy), .WRITE_DROP(aDrop)
    );

    reg_file_param #(
        .DATA_W(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(1)
    ) dutB (
        .CLK(CLK), .RESET_N(RESET_N), .IN(bIn), .INADDRESS(bInAddr), .WRITE(bWrite),
        .OUT1ADDRESS(bO1Addr), .OUT2ADDRESS(bO2Addr), .OUT1(bOut1), .OUT2(bOut2),
        .CLEAR(bClear), .BUSY(bBusy), .WRITE_DROP(bDrop)
    );

    always #10 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        aWrite  = 1'b1;
        aInAddr = addr;
        aIn     = data;
        waitCycle();
        aWrite  = 1'b0;
    endtask

    task automatic readA(input logic [2:0] addr, input logic [7:0] exp, input string tag);
        aO1Addr = addr;
        #1;
        checkOutput(tag, {8'h00, aOut1}, {8'h00, exp});
    endtask

    initial begin
        aIn = '0; aInAddr = '0; aO1Addr = '0; aO2Addr = '0; aWrite = 1'b0; aClear = 1'b0;
        bIn = '0; bInAddr = '0; bO1Addr = '0; bO2Addr = '0; bWrite = 1'b0; bClear = 1'b0;

        // Reset then read everything back as zero.
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            aO1Addr = 3'(i);
            aO2Addr = 3'(7 - i);
            #1;
            checkOutput($sformatf("reset OUT1 R%0d", i), {8'h00, aOut1}, 16'h0000);
            checkOutput($sformatf("reset OUT2 R%0d", 7 - i), {8'h00, aOut2}, 16'h0000);
        end
        checkBit("reset BUSY", aBusy, 1'b0);
        checkBit("reset WRITE_DROP", aDrop, 1'b0);
        checkBit("reset BUSY B", bBusy, 1'b0);

        // Write/readback with same-cycle bypass.
        aWrite = 1'b1; aInAddr = 3'd3; aIn = 8'h5A; aO1Addr = 3'd3;
        #1;
        checkOutput("bypass R3", {8'h00, aOut1}, 16'h005A);
        waitCycle();
        aInAddr = 3'd6; aIn = 8'hC3;
        waitCycle();
        aWrite = 1'b0; aO1Addr = 3'd3; aO2Addr = 3'd6;
        #1;
        checkOutput("readback R3", {8'h00, aOut1}, 16'h005A);
        checkOutput("readback R6", {8'h00, aOut2}, 16'h00C3);
        checkBit("no drop on normal write", aDrop, 1'b0);

        // Fill R0..R7 with 0x11..0x88, then bulk clear with a dropped write.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 8'((i + 1) * 17));
        end
        readA(3'd7, 8'h88, "fill R7");
        readA(3'd0, 8'h11, "fill R0");
        aClear = 1'b1;
        waitCycle();
        aClear = 1'b0;
        checkBit("BUSY after CLEAR edge", aBusy, 1'b1);
        readA(3'd0, 8'h11, "CLEAR edge keeps R0");
        for (int k = 0; k < 8; k++) begin
            aO1Addr = 3'(k);
            aO2Addr = 3'(k + 1);
            if (k == 3) begin
                aWrite = 1'b1; aInAddr = 3'd2; aIn = 8'hFF; aO2Addr = 3'd2;
                #1;
                checkOutput("no bypass while BUSY", {8'h00, aOut2}, 16'h0000);
                aO2Addr = 3'(k + 1);
            end
            waitCycle();
            #1;
            checkOutput($sformatf("cleared R%0d", k), {8'h00, aOut1}, 16'h0000);
            if (k < 7) begin
                checkOutput($sformatf("not yet cleared R%0d", k + 1), {8'h00, aOut2},
                            {8'h00, 8'((k + 2) * 17)});
            end
            checkBit($sformatf("BUSY during clear step %0d", k), aBusy, (k < 7));
            if (k == 3) begin
                checkBit("WRITE_DROP after busy write", aDrop, 1'b1);
                aWrite = 1'b0;
            end
            if (k == 4) begin
                checkBit("WRITE_DROP falls", aDrop, 1'b0);
            end
        end
        readA(3'd2, 8'h00, "R2 after dropped write");
        applyStimulus(3'd4, 8'h99);
        readA(3'd4, 8'h99, "write accepted after BUSY falls");

        // CLEAR and WRITE together in IDLE: clear wins, write dropped.
        applyStimulus(3'd1, 8'h10);
        aWrite = 1'b1; aInAddr = 3'd1; aIn = 8'h42; aClear = 1'b1; aO1Addr = 3'd1;
        #1;
        checkOutput("no bypass with CLEAR", {8'h00, aOut1}, 16'h0010);
        waitCycle();
        aWrite = 1'b0; aClear = 1'b0;
        #1;
        checkBit("WRITE_DROP with CLEAR", aDrop, 1'b1);
        checkBit("BUSY with CLEAR", aBusy, 1'b1);
        checkOutput("R1 keeps old value", {8'h00, aOut1}, 16'h0010);
        repeat (8) waitCycle();
        checkBit("BUSY done after 8", aBusy, 1'b0);
        checkOutput("R1 cleared", {8'h00, aOut1}, 16'h0000);

        // Reset in the middle of a clear.
        applyStimulus(3'd7, 8'hAB);
        applyStimulus(3'd5, 8'h55);
        aClear = 1'b1;
        waitCycle();
        aClear = 1'b0;
        repeat (3) waitCycle();
        checkBit("BUSY mid-clear", aBusy, 1'b1);
        readA(3'd7, 8'hAB, "R7 before reset");
        RESET_N = 1'b0;
        #1;
        checkBit("BUSY drops on reset", aBusy, 1'b0);
        checkBit("WRITE_DROP on reset", aDrop, 1'b0);
        readA(3'd7, 8'h00, "R7 after reset");
        readA(3'd5, 8'h00, "R5 after reset");
        waitCycle();
        waitCycle();
        RESET_N = 1'b1;
        applyStimulus(3'd5, 8'h77);
        readA(3'd5, 8'h77, "first write after reset");
        checkBit("BUSY after reset release", aBusy, 1'b0);

        // Wide instance with hardwired-zero R0.
        bWrite = 1'b1; bInAddr = 4'd0; bIn = 16'hBEEF; bO1Addr = 4'd0;
        #1;
        checkOutput("R0 zero beats bypass", bOut1, 16'h0000);
        waitCycle();
        bWrite = 1'b0;
        #1;
        checkOutput("R0 ignores write", bOut1, 16'h0000);
        checkBit("R0 write no drop", bDrop, 1'b0);
        bWrite = 1'b1; bInAddr = 4'd15; bIn = 16'hBEEF; bO2Addr = 4'd15;
        waitCycle();
        bWrite = 1'b0;
        #1;
        checkOutput("R15 readback", bOut2, 16'hBEEF);

        bClear = 1'b1; bWrite = 1'b1; bInAddr = 4'd15; bIn = 16'h1234;
        waitCycle();
        bClear = 1'b0;
        busyCycles = 0;
        checkBit("B drop with CLEAR", bDrop, 1'b1);
        if (bBusy) busyCycles++;
        waitCycle();
        bWrite = 1'b0;
        checkBit("B drop back-to-back", bDrop, 1'b1);
        if (bBusy) busyCycles++;
        waitCycle();
        checkBit("B drop falls", bDrop, 1'b0);
        guard = 0;
        while (bBusy && guard < 40) begin
            busyCycles++;
            guard++;
            waitCycle();
        end
        checkOutput("B BUSY cycle count", 16'(busyCycles), 16'd16);
        checkOutput("R15 after clear", bOut2, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
